// File: rtl/mem_sweep_driver.sv
// mem_sweep_driver: command-driven sequencer for a 16 x 8 synchronous memory.
// Commands: WRITE/READ a single byte, FILL all 16 bytes with seed+k, VERIFY all
// 16 bytes against seed+k and report mismatch count and first mismatching address.
// Ports:
//   clk, rst_n                       clock, asynchronous active-low reset
//   cmd_valid_i/cmd_ready_o          command handshake; cmd_op_i, cmd_addr_i, cmd_data_i fields
//   mem_en_o/mem_we_o/mem_addr_o/mem_wdata_o  memory strobe; mem_rdata_i valid one cycle later
//   rsp_valid_o/rsp_ready_i          response handshake; rsp_data_o, rsp_err_o, rsp_err_addr_o
//   busy_o                           high whenever the FSM is not idle
module mem_sweep_driver (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       cmd_valid_i,
   output logic       cmd_ready_o,
   input  logic [1:0] cmd_op_i,
   input  logic [3:0] cmd_addr_i,
   input  logic [7:0] cmd_data_i,
   output logic       mem_en_o,
   output logic       mem_we_o,
   output logic [3:0] mem_addr_o,
   output logic [7:0] mem_wdata_o,
   input  logic [7:0] mem_rdata_i,
   output logic       rsp_valid_o,
   input  logic       rsp_ready_i,
   output logic [7:0] rsp_data_o,
   output logic       rsp_err_o,
   output logic [3:0] rsp_err_addr_o,
   output logic       busy_o
);

   localparam logic [1:0] OpWrite  = 2'b00;
   localparam logic [1:0] OpRead   = 2'b01;
   localparam logic [1:0] OpFill   = 2'b10;
   localparam logic [1:0] OpVerify = 2'b11;

   typedef enum logic [2:0] {StIdle, StWrite, StRead, StRwait, StSweep, StVdrain, StResp} state_e;

   state_e     state_q, state_d;
   logic       rdy_q;
   logic [1:0] op_q, op_d;
   logic [3:0] addr_q, addr_d;
   logic [7:0] data_q, data_d;
   logic [3:0] k_q, k_d;
   logic [7:0] rd_q, rd_d;
   logic [4:0] cnt_q, cnt_d;
   logic       seen_q, seen_d;
   logic [3:0] eaddr_q, eaddr_d;
   // A verify read issued last cycle whose data is on mem_rdata_i now.
   logic       cmp_pend_q, cmp_pend_d;
   logic [3:0] cmp_k_q, cmp_k_d;

   always_comb begin
      state_d        = state_q;
      op_d           = op_q;
      addr_d         = addr_q;
      data_d         = data_q;
      k_d            = k_q;
      rd_d           = rd_q;
      cnt_d          = cnt_q;
      seen_d         = seen_q;
      eaddr_d        = eaddr_q;
      cmp_pend_d     = 1'b0;
      cmp_k_d        = cmp_k_q;
      cmd_ready_o    = 1'b0;
      mem_en_o       = 1'b0;
      mem_we_o       = 1'b0;
      mem_addr_o     = 4'd0;
      mem_wdata_o    = 8'd0;
      rsp_valid_o    = 1'b0;
      rsp_data_o     = 8'd0;
      rsp_err_o      = 1'b0;
      rsp_err_addr_o = 4'd0;
      busy_o         = (state_q != StIdle);

      if (cmp_pend_q && (mem_rdata_i != (data_q + {4'd0, cmp_k_q}))) begin
         cnt_d = cnt_q + 5'd1;
         if (!seen_q) begin
            seen_d  = 1'b1;
            eaddr_d = cmp_k_q;
         end
      end

      unique case (state_q)
         StIdle: begin
            // rdy_q keeps cmd_ready low until the first edge after reset release.
            cmd_ready_o = rdy_q;
            if (cmd_valid_i && rdy_q) begin
               op_d   = cmd_op_i;
               addr_d = cmd_addr_i;
               data_d = cmd_data_i;
               k_d    = 4'd0;
               if (cmd_op_i == OpVerify) begin
                  cnt_d   = 5'd0;
                  seen_d  = 1'b0;
                  eaddr_d = 4'd0;
               end
               unique case (cmd_op_i)
                  OpWrite: state_d = StWrite;
                  OpRead:  state_d = StRead;
                  default: state_d = StSweep;
               endcase
            end
         end
         StWrite: begin
            mem_en_o    = 1'b1;
            mem_we_o    = 1'b1;
            mem_addr_o  = addr_q;
            mem_wdata_o = data_q;
            state_d     = StResp;
         end
         StRead: begin
            mem_en_o   = 1'b1;
            mem_addr_o = addr_q;
            state_d    = StRwait;
         end
         StRwait: begin
            rd_d    = mem_rdata_i;
            state_d = StResp;
         end
         StSweep: begin
            mem_en_o   = 1'b1;
            mem_addr_o = k_q;
            if (op_q == OpFill) begin
               mem_we_o    = 1'b1;
               mem_wdata_o = data_q + {4'd0, k_q};
            end else begin
               cmp_pend_d = 1'b1;
               cmp_k_d    = k_q;
            end
            // Counter holds at 15; the sweep ends there instead of wrapping.
            if (k_q == 4'd15) begin
               state_d = (op_q == OpFill) ? StResp : StVdrain;
            end else begin
               k_d = k_q + 4'd1;
            end
         end
         StVdrain: begin
            state_d = StResp;
         end
         StResp: begin
            rsp_valid_o = 1'b1;
            if (op_q == OpRead) begin
               rsp_data_o = rd_q;
            end else if (op_q == OpVerify) begin
               rsp_data_o     = {3'd0, cnt_q};
               rsp_err_o      = (cnt_q != 5'd0);
               rsp_err_addr_o = eaddr_q;
            end
            if (rsp_ready_i) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= StIdle;
         rdy_q      <= 1'b0;
         op_q       <= 2'd0;
         addr_q     <= 4'd0;
         data_q     <= 8'd0;
         k_q        <= 4'd0;
         rd_q       <= 8'd0;
         cnt_q      <= 5'd0;
         seen_q     <= 1'b0;
         eaddr_q    <= 4'd0;
         cmp_pend_q <= 1'b0;
         cmp_k_q    <= 4'd0;
      end else begin
         state_q    <= state_d;
         rdy_q      <= 1'b1;
         op_q       <= op_d;
         addr_q     <= addr_d;
         data_q     <= data_d;
         k_q        <= k_d;
         rd_q       <= rd_d;
         cnt_q      <= cnt_d;
         seen_q     <= seen_d;
         eaddr_q    <= eaddr_d;
         cmp_pend_q <= cmp_pend_d;
         cmp_k_q    <= cmp_k_d;
      end
   end

endmodule

// File: doc/mem_sweep_driver.md
MEM_SWEEP_DRIVER -- requirements
Module: mem_sweep_driver

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset; all other ports are listed below.
REQ-002 clk  in  1  rising-edge clock for all state.
REQ-003 rst_n  in  1  asynchronous active-low reset.
REQ-004 cmd_valid  in  1  command offered.
REQ-005 cmd_ready  out  1  command accepted this cycle when cmd_valid and cmd_ready are both 1.
REQ-006 cmd_op  in  2  00 = WRITE, 01 = READ, 10 = FILL, 11 = VERIFY.
REQ-007 cmd_addr  in  4  target address for WRITE/READ; ignored by FILL/VERIFY.
REQ-008 cmd_data  in  8  write byte (WRITE) or pattern seed (FILL/VERIFY).
REQ-009 mem_en  out  1  memory access strobe.
REQ-010 mem_we  out  1  write qualifier, valid only with mem_en.
REQ-011 mem_addr  out  4  memory address.
REQ-012 mem_wdata  out  8  memory write data.
REQ-013 mem_rdata  in  8  read data, valid the cycle after a read strobe (mem_en=1, mem_we=0).
REQ-014 rsp_valid  out  1  response pending.
REQ-015 rsp_ready  in  1  response consumed when rsp_valid and rsp_ready are both 1.
REQ-016 rsp_data  out  8  read byte (READ), mismatch count (VERIFY), 0 otherwise.
REQ-017 rsp_err  out  1  VERIFY found at least one mismatch.
REQ-018 rsp_err_addr  out  4  first mismatching address (VERIFY), 0 otherwise.
REQ-019 busy  out  1  high in every state except IDLE.

Function
REQ-020 The FSM SHALL use states IDLE, WRITE, READ, RWAIT, SWEEP, VDRAIN and RESP.
REQ-021 cmd_ready SHALL be 1 in IDLE only; accepted fields are registered, so later cmd_* changes have no effect.
REQ-022 On acceptance at cycle T, the FSM SHALL move from IDLE to WRITE, READ or SWEEP according to cmd_op.
REQ-023 WRITE: at T+1, mem_en=1, mem_we=1, mem_addr=cmd_addr, mem_wdata=cmd_data; RESP is entered at T+2.
REQ-024 READ: at T+1, mem_en=1, mem_we=0; at T+2 (RWAIT), mem_rdata is captured into rsp_data; RESP is entered at T+3.
REQ-025 FILL: at T+1..T+16, one write per cycle to address k = 0..15 with mem_wdata = (cmd_data + k) mod 256; RESP is entered at T+17.
REQ-026 VERIFY: at T+1..T+16, one read per cycle to k = 0..15.
REQ-027 VERIFY: mem_rdata for address k SHALL be compared at T+2+k against (cmd_data + k) mod 256; the last compare occurs in VDRAIN at T+17, and RESP is entered at T+18.
REQ-028 VERIFY: each mismatch SHALL increment a 5-bit counter (saturation unnecessary, max 16) that is zero-extended into rsp_data.
REQ-029 VERIFY: rsp_err_addr SHALL latch the first mismatching k only; rsp_err = (count != 0).
REQ-030 mem_en SHALL be 0 in IDLE, RWAIT, VDRAIN and RESP; mem_we, mem_addr and mem_wdata SHALL be 0 whenever mem_en=0.
REQ-031 In RESP, rsp_valid SHALL be 1 with all rsp_* stable until rsp_ready; the handshake cycle returns the FSM to IDLE, and rsp_valid=0 the next cycle.
REQ-032 A new command SHALL be accepted no earlier than the cycle after the response handshake; there is no overlap or back-to-back bypass.
REQ-033 The 4-bit sweep address counter SHALL stop at 15 and never wrap into a 17th access.
REQ-034 Pattern addition SHALL be 8-bit modulo: seed 0xF8 at k=15 gives 0x07.
REQ-035 The verify counter and first-error flag SHALL be cleared when each VERIFY command is accepted.
REQ-036 If rsp_ready is held 1 before RESP, the response SHALL complete in the first RESP cycle.

Reset
REQ-037 While rst_n=0, the FSM SHALL be in IDLE and cmd_ready=0.
REQ-038 While rst_n=0, all other outputs SHALL be 0: mem_*, rsp_*, busy.
REQ-039 Assertion mid-operation SHALL abort immediately with no further mem_en; memory contents are not restored.
REQ-040 After rst_n rises, cmd_ready SHALL be 1 from the first clock edge.

Verification
REQ-041 WRITE addr 3 data 0xA5, then READ addr 3 -> rsp_data=0xA5, rsp_valid at T+3 of the read.
REQ-042 FILL seed 0x10 -> 16 consecutive write strobes, addresses 0..15, data 0x10..0x1F; rsp_valid at T+17 with rsp_data=0 and rsp_err=0.
REQ-043 FILL seed 0xF8, then VERIFY seed 0xF8 -> rsp_err=0, rsp_data=0; rsp_valid at T+18.
REQ-044 FILL 0x00, WRITE addr 5 0xFF, WRITE addr 9 0xFF, VERIFY 0x00 -> rsp_data=2, rsp_err=1, rsp_err_addr=5.
REQ-045 Hold rsp_ready=0 for 5 cycles in RESP while driving cmd_valid -> rsp stable, cmd_ready=0, no mem_en; the command is accepted only after the handshake.
REQ-046 Drop rst_n at sweep step 7 of a FILL -> all outputs 0 the same cycle, no further writes, cmd_ready=1 after release.
